addsub_arbiter: RTL

- Arbitration controller that shares one combinational 4-bit adder/subtractor unit between two independent requesters.
- The shared unit uses a control input that both inverts b and acts as carry-in.
- The block accepts operand/op requests over valid/ready handshakes, grants them round-robin, and drives the shared unit from registered operands.
- It captures sum, carry and signed overflow, and returns each result on a per-requester response channel held until acknowledged.

---
 rtl/addsub_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// ============================================================================
// addsub_arbiter : round-robin arbiter sharing one add/sub unit between two
//                  requesters, with per-requester held response channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module addsub_arbiter #(
  parameter int WIDTH     = 4,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_ctrl,
  input  logic [WIDTH-1:0] au_s,
  input  logic             au_cout,
  output logic             rsp0_valid,
  input  logic             rsp0_ack,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_cout,
  output logic             rsp0_ovf,
  output logic             rsp1_valid,
  input  logic             rsp1_ack,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_cout,
  output logic             rsp1_ovf
);

  localparam int c_MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_gnt;
  logic             w_grant;
  logic             w_accept;
  logic             w_ack;
  logic             w_ovf;
  logic [WIDTH-1:0] r_au_a;
  logic [WIDTH-1:0] r_au_b;
  logic             r_au_ctrl;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_s, r_rsp1_s;
  logic             r_rsp0_cout, r_rsp1_cout;
  logic             r_rsp0_ovf, r_rsp1_ovf;

  // Priority only matters when both requesters contend.
  assign w_grant  = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign w_accept = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_ack    = r_gnt ? rsp1_ack : rsp0_ack;

  // Overflow: operands (b as seen by the adder) share a sign the sum lacks.
  assign w_ovf = (r_au_a[c_MSB] == (r_au_b[c_MSB] ^ r_au_ctrl)) &&
                 (au_s[c_MSB] != r_au_a[c_MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid && w_grant;
        if (w_accept) w_state_nxt = S_EXEC;
      end
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio       <= PRIO_INIT;
      r_gnt        <= 1'b0;
      r_au_a       <= '0;
      r_au_b       <= '0;
      r_au_ctrl    <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_s     <= '0;
      r_rsp0_cout  <= 1'b0;
      r_rsp0_ovf   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_s     <= '0;
      r_rsp1_cout  <= 1'b0;
      r_rsp1_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt     <= w_grant;
        r_au_a    <= w_grant ? req1_a   : req0_a;
        r_au_b    <= w_grant ? req1_b   : req0_b;
        r_au_ctrl <= w_grant ? req1_sub : req0_sub;
      end
      if (r_state == S_EXEC) begin
        if (r_gnt) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_s     <= au_s;
          r_rsp1_cout  <= au_cout;
          r_rsp1_ovf   <= w_ovf;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_s     <= au_s;
          r_rsp0_cout  <= au_cout;
          r_rsp0_ovf   <= w_ovf;
        end
      end
      if ((r_state == S_RESP) && w_ack) begin
        if (r_gnt) r_rsp1_valid <= 1'b0;
        else       r_rsp0_valid <= 1'b0;
        r_prio <= ~r_gnt;
      end
    end
  end

  assign au_a       = r_au_a;
  assign au_b       = r_au_b;
  assign au_ctrl    = r_au_ctrl;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_s     = r_rsp0_s;
  assign rsp0_cout  = r_rsp0_cout;
  assign rsp0_ovf   = r_rsp0_ovf;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_s     = r_rsp1_s;
  assign rsp1_cout  = r_rsp1_cout;
  assign rsp1_ovf   = r_rsp1_ovf;

endmodule

`default_nettype wire
